mem_fill_arbiter: RTL
=====================

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of cache requestors (index 0 = D-cache, 1 = I-cache).
REQ-002 SHALL have parameter WORDS, default 8, 16-bit words per block (power of 2, 2..16).
REQ-003 SHALL have parameter MEM_LAT, default 4, cycles from mem_en to mem_data_valid.
REQ-004 SHALL have parameter ARB_MODE, default 0; 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset, as the port list below states.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 miss_req  input  NUM_REQ  per-requestor fill request, level.
REQ-009 miss_addr  input  16*NUM_REQ  per-requestor byte address of missing word.
REQ-010 mem_data_in  input  16  word returned by memory.
REQ-011 mem_data_valid  input  1  mem_data_in valid this cycle.
REQ-012 mem_en  output  1  issue a read this cycle.
REQ-013 mem_addr  output  16  read byte address.
REQ-014 fill_grant  output  NUM_REQ  one-hot owner of the current fill, zero when idle.
REQ-015 fill_valid  output  1  fill_data/fill_word valid this cycle.
REQ-016 fill_data  output  16  word forwarded to the owner.
REQ-017 fill_word  output  log2(WORDS)  word offset within the block.
REQ-018 fill_done  output  NUM_REQ  one-cycle completion pulse to the owner.

Function
REQ-019 SHALL implement states IDLE, FILL, DONE.
REQ-020 IDLE: when any miss_req bit is high, SHALL pick a winner per ARB_MODE, latch its block base = miss_addr with bits [log2(WORDS):0] cleared, set fill_grant, go to FILL next cycle.
REQ-021 FILL: SHALL assert mem_en for WORDS consecutive cycles, mem_addr = base + 2*issue_cnt, issue_cnt 0..WORDS-1, first issue in the first FILL cycle.
REQ-022 FILL: on each mem_data_valid SHALL set fill_valid, pass mem_data_in to fill_data combinationally, fill_word = rx_cnt, increment rx_cnt.
REQ-023 SHALL go to DONE the cycle after the word with rx_cnt = WORDS-1 is received; total FILL length = WORDS+MEM_LAT-1 cycles.
REQ-024 DONE: SHALL pulse fill_done[owner] for exactly one cycle, clear fill_grant, return to IDLE; requests are not sampled in DONE.
REQ-025 Round robin: after each grant, priority pointer SHALL become (winner+1) mod NUM_REQ; the search starts at the pointer and wraps.
REQ-026 Deassertion of the owner's miss_req during FILL SHALL NOT abort the fill; miss_addr changes during FILL SHALL be ignored.
REQ-027 mem_data_valid in IDLE or DONE SHALL be ignored (no fill_valid).
REQ-028 Block addresses SHALL not wrap: the block at 0xFFF0 (WORDS = 8) issues 0xFFF0..0xFFFE.
REQ-029 A requestor SHALL deassert miss_req in the cycle after fill_done; a still-high request SHALL be re-granted in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE; all outputs 0; issue_cnt, rx_cnt 0; RR pointer 0.
REQ-031 Reset during FILL SHALL abort the fill with no fill_done; data returning after reset release SHALL be ignored per REQ-027.

Structure
REQ-032 State encoding and default parameter constants SHALL live in shared package wisc_mem_pkg.
REQ-033 Arbitration SHALL be a sub-module rr_arbiter (NUM_REQ, ARB_MODE; request vector in, one-hot grant out, pointer internal).

Verification
REQ-034 Single request: D-cache req at 0x1234, mem returns 0xA000+i -> mem_addr 0x1230..0x123E over 8 cycles; fill_word 0..7 with data 0xA000..0xA007; fill_done[0] at FILL cycle 12.
REQ-035 Simultaneous req[0], req[1], ARB_MODE 0 -> D-cache served first, I-cache granted in the IDLE cycle after DONE.
REQ-036 ARB_MODE 1, both requests held high for 4 fills -> grant order 0,1,0,1.
REQ-037 Owner drops miss_req after 2 cycles of FILL -> all 8 words delivered and fill_done pulsed.
REQ-038 rst_n low at FILL cycle 5 -> outputs 0 immediately; stray mem_data_valid after release gives no fill_valid; new request then fills normally.
REQ-039 Request at 0xFFFF -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the memory fill arbiter.
// Provides the default parameter values, bus widths, the fill FSM state type
// and a helper that rounds a byte address down to the start of its block.
package wisc_mem_pkg;

  localparam int unsigned DefNumReq  = 2;
  localparam int unsigned DefWords   = 8;
  localparam int unsigned DefMemLat  = 4;
  localparam int unsigned DefArbMode = 0;

  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

  // A block of 2^word_bits 16-bit words spans 2^(word_bits+1) bytes, so the
  // low word_bits+1 address bits are cleared to get the block base.
  function automatic logic [AddrW-1:0] block_base(input logic [AddrW-1:0] addr,
                                                  input int unsigned      word_bits);
    logic [AddrW-1:0] mask;
    mask = {AddrW{1'b1}} << (word_bits + 1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the fill engine.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   req_i         : request vector, one bit per requestor
//   advance_i     : a grant is being taken this cycle; moves the priority pointer
//   gnt_o         : one-hot grant (zero when no request)
// ARB_MODE 0 is fixed priority (lowest index wins); ARB_MODE 1 is round robin
// with the search starting at the pointer, which becomes winner+1 after a grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] start;
  logic [PtrW-1:0] idx;
  logic [PtrW-1:0] winner;
  logic            found;

  always_comb begin
    gnt_o  = '0;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    start  = (ARB_MODE == 1) ? ptr_q : '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PtrW'((32'(start) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = PtrW'((32'(winner) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Cache block fill engine shared by several cache requestors (0 = D-cache,
// 1 = I-cache). A winner is picked in IDLE, its block is read from memory one
// 16-bit word per cycle in FILL, returned words are forwarded to the owner, and
// a one-cycle fill_done pulse is given in DONE.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   miss_req        : per-requestor fill request (level)
//   miss_addr       : per-requestor byte address, 16 bits each, requestor 0 in LSBs
//   mem_data_in     : word returned by memory, qualified by mem_data_valid
//   mem_en/mem_addr : read request to memory
//   fill_grant      : one-hot owner of the fill in progress, zero when idle
//   fill_valid/fill_data/fill_word : returned word and its offset in the block
//   fill_done       : one-cycle completion pulse to the owner
module mem_fill_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned WORDS    = DefWords,
  parameter int unsigned MEM_LAT  = DefMemLat,
  parameter int unsigned ARB_MODE = DefArbMode
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       miss_req,
  input  logic [AddrW*NUM_REQ-1:0] miss_addr,
  input  logic [DataW-1:0]         mem_data_in,
  input  logic                     mem_data_valid,
  output logic                     mem_en,
  output logic [AddrW-1:0]         mem_addr,
  output logic [NUM_REQ-1:0]       fill_grant,
  output logic                     fill_valid,
  output logic [DataW-1:0]         fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [NUM_REQ-1:0]       fill_done
);

  localparam int unsigned WordW = $clog2(WORDS);
  localparam int unsigned CntW  = WordW + 1;

  if (WORDS < 2 || WORDS > 16 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
    $error("mem_fill_arbiter: WORDS must be a power of 2 in 2..16");
  end
  // The engine counts returned words rather than cycles, so MEM_LAT only
  // needs to be a sane latency.
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_fill_arbiter: MEM_LAT must be at least 1");
  end
  if (ARB_MODE > 1) begin : g_bad_mode
    $error("mem_fill_arbiter: ARB_MODE must be 0 or 1");
  end

  fill_state_e        state_q, state_d;
  logic [AddrW-1:0]   base_q, base_d;
  logic [CntW-1:0]    issue_cnt_q, issue_cnt_d;
  logic [WordW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_advance;
  logic [AddrW-1:0]   sel_addr;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (miss_req),
    .advance_i (arb_advance),
    .gnt_o     (arb_gnt)
  );

  // Address of the requestor the arbiter picks this cycle.
  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = miss_addr[AddrW*i +: AddrW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    grant_d     = grant_q;
    arb_advance = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fill_valid  = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    fill_done   = '0;

    unique case (state_q)
      StIdle: begin
        if (|miss_req) begin
          grant_d     = arb_gnt;
          base_d      = block_base(sel_addr, WordW);
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          arb_advance = 1'b1;
          state_d     = StFill;
        end
      end
      StFill: begin
        // Issue side and return side run independently; issue_cnt saturates
        // at WORDS once every read has been sent.
        if (issue_cnt_q < CntW'(WORDS)) begin
          mem_en      = 1'b1;
          mem_addr    = base_q + AddrW'({issue_cnt_q, 1'b0});
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (mem_data_valid) begin
          fill_valid = 1'b1;
          fill_data  = mem_data_in;
          fill_word  = rx_cnt_q;
          rx_cnt_d   = rx_cnt_q + 1'b1;
          if (rx_cnt_q == WordW'(WORDS - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        fill_done = grant_q;
        grant_d   = '0;
        state_d   = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign fill_grant = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      grant_q     <= grant_d;
    end
  end

endmodule
